pc_unit_segmented: RTL
======================

Name: pc_unit_segmented

Overview:
- Parametrised program-counter unit for the segmented RISC-V core's IF stage.
- Successor to the plain enable-gated PC register: adds internal next-PC generation, prioritised trap/branch redirect, and a fetch-ready handshake.
- Also holds a redirect that arrives during a hazard stall, so it is applied when the stall releases rather than lost.
- Sits between the hazard unit / EX-stage branch resolution and the instruction-memory fetch port.

Parameters:
XLEN, 32, PC and target width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
INSTR_BYTES, 4, sequential increment in bytes
ALIGN_BITS, 2, number of low PC bits that must be zero for an aligned fetch (>=1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
pc_write_enable  in  1  hazard-unit advance permission; 0 = stall
fetch_ready  in  1  IF stage accepts the current pc_out this cycle
branch_valid  in  1  EX-stage taken branch/jump redirect request
branch_target  in  XLEN  branch/jump destination
trap_valid  in  1  exception/trap redirect request
trap_target  in  XLEN  trap vector address
pc_out  out  XLEN  current fetch address
pc_plus_step  out  XLEN  pc_out + INSTR_BYTES, combinational, modulo 2^XLEN
pc_valid  out  1  pc_out is a valid fetch request
misaligned  out  1  pc_valid && (pc_out[ALIGN_BITS-1:0] != 0), combinational
redirect_pending  out  1  a redirect is latched and waiting for the stall to release

Behaviour:
- Single clock domain, clk. reset is synchronous and active-high, sampled on the rising edge of clk, and overrides all other inputs.
- Reset values: pc_out=RESET_VECTOR, pc_valid=0, redirect_pending=0, pending target=0, state=BOOT.
- States: BOOT, RUN, HOLD.
  - BOOT: pc_valid=0. Next edge -> RUN, pc_out unchanged (RESET_VECTOR). Redirect inputs in BOOT are treated as in RUN.
  - RUN: pc_valid=1.
  - HOLD: pc_valid=0 (current pc_out is stale). redirect_pending=1.
- Request priority each cycle (state RUN or BOOT): trap_valid > branch_valid > sequential.
  - Redirect with pc_write_enable=1: pc_out <= target on the next edge, state RUN. Independent of fetch_ready: the redirect kills the in-flight fetch. Latency is 1 cycle.
  - Redirect with pc_write_enable=0: pending target <= target, record its kind (trap/branch), state -> HOLD. pc_out unchanged.
  - Sequential: if pc_valid && fetch_ready && pc_write_enable, pc_out <= pc_out + INSTR_BYTES, wrapping modulo 2^XLEN. Otherwise pc_out holds.
- In HOLD:
  - A new trap_valid overwrites the pending target, whether the pending redirect is a branch or a trap.
  - A new branch_valid overwrites a pending branch but never a pending trap.
  - When pc_write_enable=1: pc_out <= the newest qualifying target (same-cycle trap > same-cycle branch > pending), pending cleared, state RUN. pc_valid=1 on the following cycle.
  - No sequential increment occurs while in HOLD.
- A redirect target is loaded unmodified, including misaligned values. misaligned flags it; the PC unit takes no other action.
- Simultaneous trap_valid and branch_valid: trap_target wins, branch is discarded.
- Reset asserted in any state (including HOLD with a pending redirect): the pending redirect is discarded and all reset values apply on that edge.
- pc_plus_step is combinational from pc_out, valid in all states.

Test Plan:
- Reset with RESET_VECTOR=32'h0000_0100 -> pc_out=0x100, pc_valid=0 during reset and for one cycle after it deasserts (BOOT). Then, with fetch_ready=1 and pc_write_enable=1: pc_valid=1, and pc_out steps 0x100, 0x104, 0x108 on successive edges.
- Advance gating: fetch_ready=0 for 3 cycles -> pc_out holds 0x104. pc_write_enable=0 for 2 cycles -> pc_out holds. Both high -> 0x108 on the next edge.
- Branch during stall: pc_write_enable=0, branch_valid=1, branch_target=0x400 for one cycle -> redirect_pending=1, pc_valid=0, pc_out unchanged. pc_write_enable=1 two cycles later -> pc_out=0x400 on the next edge, pending cleared, pc_valid=1.
- Trap vs branch in the same cycle: trap_target=0x800, branch_target=0x400, pc_write_enable=1 -> pc_out=0x800. In HOLD with a pending trap (0x800), a branch to 0x400 arrives -> after release pc_out=0x800.
- Wrap and misalign: pc_out=0xFFFF_FFFC, advance -> pc_out=0x0000_0000. branch_target=0x402 -> pc_out=0x402, misaligned=1, pc_plus_step=0x406.
- Reset mid-HOLD: pending redirect to 0x400, assert reset -> pc_out=0x100, redirect_pending=0, state BOOT. The pending target is never applied.

Source files
------------

// File: rtl/pc_unit_segmented_if.sv
// Fetch-side bus of the segmented PC unit: hazard/EX redirect requests in,
// fetch address and status out.
interface pc_unit_segmented_if #(
    parameter int XLEN = 32
);
    logic            pc_write_enable;
    logic            fetch_ready;
    logic            branch_valid;
    logic [XLEN-1:0] branch_target;
    logic            trap_valid;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus_step;
    logic            pc_valid;
    logic            misaligned;
    logic            redirect_pending;

    modport master (
        output pc_write_enable, fetch_ready,
        output branch_valid, branch_target,
        output trap_valid, trap_target,
        input  pc_out, pc_plus_step, pc_valid, misaligned, redirect_pending
    );

    modport slave (
        input  pc_write_enable, fetch_ready,
        input  branch_valid, branch_target,
        input  trap_valid, trap_target,
        output pc_out, pc_plus_step, pc_valid, misaligned, redirect_pending
    );
endinterface

// File: rtl/pc_unit_segmented.sv
// Program-counter unit for the segmented RISC-V IF stage: sequential stepping,
// trap/branch redirect, and a held redirect that survives a hazard stall.
module pc_unit_segmented #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4,
    parameter int              ALIGN_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_unit_segmented_if.slave    bus
);

    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            pc_valid_q;
    logic            pending_q;
    logic [XLEN-1:0] pend_target;
    logic            pend_is_trap;

    logic            sel_redirect;
    logic [XLEN-1:0] sel_target;
    logic            sel_is_trap;

    // Newest qualifying redirect: a branch may never displace a held trap.
    always_comb begin
        sel_redirect = 1'b0;
        sel_target   = pend_target;
        sel_is_trap  = pend_is_trap;
        if (bus.trap_valid) begin
            sel_redirect = 1'b1;
            sel_target   = bus.trap_target;
            sel_is_trap  = 1'b1;
        end else if (bus.branch_valid && !(state == HOLD && pend_is_trap)) begin
            sel_redirect = 1'b1;
            sel_target   = bus.branch_target;
            sel_is_trap  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            pc_valid_q   <= 1'b0;
            pending_q    <= 1'b0;
            pend_target  <= '0;
            pend_is_trap <= 1'b0;
        end else begin
            case (state)
                BOOT, RUN: begin
                    if (sel_redirect && bus.pc_write_enable) begin
                        pc         <= sel_target;
                        state      <= RUN;
                        pc_valid_q <= 1'b1;
                    end else if (sel_redirect) begin
                        pend_target  <= sel_target;
                        pend_is_trap <= sel_is_trap;
                        pending_q    <= 1'b1;
                        pc_valid_q   <= 1'b0;
                        state        <= HOLD;
                    end else begin
                        if (pc_valid_q && bus.fetch_ready && bus.pc_write_enable) begin
                            pc <= pc + STEP;
                        end
                        state      <= RUN;
                        pc_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.pc_write_enable) begin
                        pc           <= sel_target;
                        pending_q    <= 1'b0;
                        pend_is_trap <= 1'b0;
                        pc_valid_q   <= 1'b1;
                        state        <= RUN;
                    end else begin
                        pend_target  <= sel_target;
                        pend_is_trap <= sel_is_trap;
                    end
                end
                default: begin
                    state      <= BOOT;
                    pc_valid_q <= 1'b0;
                    pending_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_out           = pc;
    assign bus.pc_plus_step     = pc + STEP;
    assign bus.pc_valid         = pc_valid_q;
    assign bus.redirect_pending = pending_q;
    assign bus.misaligned       = pc_valid_q && (pc[ALIGN_BITS-1:0] != '0);

endmodule
